// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serial data-memory access controller:
// access-size codes, FSM state encoding and the size-to-byte-count helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Illegal size maps to zero bytes so it never enters the access phase.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            SIZE_WORD: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Right-justified load data extension: picks the low 8/16/32 bits of the
// big-endian accumulator and zero- or sign-extends them to 32 bits.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] i_acc,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_rdata
);

    // Size-dependent extension; illegal size yields zero.
    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: o_rdata = {{24{i_signed & i_acc[7]}}, i_acc[7:0]};
            SIZE_HALF: o_rdata = {{16{i_signed & i_acc[15]}}, i_acc[15:0]};
            SIZE_WORD: o_rdata = i_acc;
            default:   o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Sequences one CPU load/store at a time onto a byte-wide memory port,
// most-significant byte at the lowest address, one byte per cycle.
module data_mem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic                r_rw;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_acc;
    logic                w_accept;
    logic [2:0]          w_nbytes;
    logic                w_last;
    logic [1:0]          w_shift;
    logic [DATA_W-1:0]   w_ext;

    assign w_accept = req_valid & req_ready;
    assign w_nbytes = size_to_nbytes(r_size);
    assign w_last   = (r_idx == 2'(w_nbytes - 3'd1));
    // Byte lane counted down from the MSB as the address counts up.
    assign w_shift  = 2'(w_nbytes - 3'd1) - r_idx;

    dmem_load_extend u_extend (
        .i_acc    (r_acc),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_rdata  (w_ext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, byte counter and load accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= 2'd0;
            r_rw     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_idx    <= 2'd0;
            r_rw     <= req_rw;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_acc    <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_idx <= r_idx + 2'd1;
            if (!r_rw) begin
                r_acc <= {r_acc[DATA_W-9:0], mem_rdata};
            end else begin
                r_acc <= r_acc;
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (req_size == SIZE_BAD) ? ST_RESP : ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: memory port only in ACCESS, response only in RESP.
    always_comb begin
        req_ready = (r_state == ST_IDLE) & ~reset;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (r_state)
            ST_ACCESS: begin
                mem_en   = 1'b1;
                mem_we   = r_rw;
                mem_addr = r_addr + ADDR_W'(r_idx);
                case (w_shift)
                    2'd0:    mem_wdata = r_wdata[7:0];
                    2'd1:    mem_wdata = r_wdata[15:8];
                    2'd2:    mem_wdata = r_wdata[23:16];
                    2'd3:    mem_wdata = r_wdata[31:24];
                    default: mem_wdata = 8'h00;
                endcase
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = (r_size == SIZE_BAD);
                if (!r_rw && (r_size != SIZE_BAD)) begin
                    rsp_rdata = w_ext;
                end else begin
                    rsp_rdata = '0;
                end
            end
            default: begin
                rsp_valid = 1'b0;
            end
        endcase
    end

endmodule
